// File: rtl/karatsuba32_seq.sv
// Sequential 32x32 unsigned Karatsuba multiplier sharing one external 18x18 unit
// over three partial products (HH, LL, MM), recombined into a 64-bit product.
module karatsuba32_seq #(
  parameter int WIDTH = 32,
  parameter int HALF  = WIDTH / 2,
  parameter int MUL_W = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p,
  output logic [MUL_W-1:0]     mul_x,
  output logic [MUL_W-1:0]     mul_y,
  input  logic [2*MUL_W-1:0]   mul_p
);

  localparam int PROD_W = 2 * MUL_W;
  localparam int MID_W  = PROD_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    HH,
    LL,
    MM,
    COMB
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [PROD_W-1:0]    z2;
  logic [PROD_W-1:0]    z0;
  logic [PROD_W-1:0]    z1;
  logic [HALF:0]        sa;
  logic [HALF:0]        sb;

  // An approximate multiplier can make z1 < z2 + z0, so mid must be signed
  // and sign-extended before shifting into the 64-bit sum.
  function automatic logic [2*WIDTH-1:0] recombine(
    input logic [PROD_W-1:0] hi,
    input logic [PROD_W-1:0] mi,
    input logic [PROD_W-1:0] lo
  );
    logic signed [MID_W-1:0] mid;
    logic [2*WIDTH-1:0]      mid_ext;
    mid     = $signed({2'b00, mi}) - $signed({2'b00, hi}) - $signed({2'b00, lo});
    mid_ext = {{(2*WIDTH-MID_W){mid[MID_W-1]}}, mid};
    return ((2*WIDTH)'(hi) << WIDTH) + (mid_ext << HALF) + (2*WIDTH)'(lo);
  endfunction

  assign sa   = {1'b0, a_r[WIDTH-1:HALF]} + {1'b0, a_r[HALF-1:0]};
  assign sb   = {1'b0, b_r[WIDTH-1:HALF]} + {1'b0, b_r[HALF-1:0]};
  assign busy = (state != IDLE);

  // Operand mux: state decode -> multiplier -> z register is the critical path.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state)
      HH: begin
        mul_x = MUL_W'(a_r[WIDTH-1:HALF]);
        mul_y = MUL_W'(b_r[WIDTH-1:HALF]);
      end
      LL: begin
        mul_x = MUL_W'(a_r[HALF-1:0]);
        mul_y = MUL_W'(b_r[HALF-1:0]);
      end
      MM: begin
        mul_x = MUL_W'(sa);
        mul_y = MUL_W'(sb);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      p     <= '0;
      a_r   <= '0;
      b_r   <= '0;
      z2    <= '0;
      z0    <= '0;
      z1    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            state <= HH;
          end
        end
        HH: begin
          z2    <= mul_p;
          state <= LL;
        end
        LL: begin
          z0    <= mul_p;
          state <= MM;
        end
        MM: begin
          z1    <= mul_p;
          state <= COMB;
        end
        COMB: begin
          p     <= recombine(z2, z1, z0);
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba32_seq.sv
// Bench for karatsuba32_seq: exact and approximate external multiplier models,
// directed cases plus random operands against a behavioural reference.
module tb_karatsuba32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] p;
  logic [17:0] mul_x;
  logic [17:0] mul_y;
  logic [35:0] mul_p;
  bit          approx_en = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // External 18x18 unit: exact, or exact product with bits [7:4] perturbed.
  function automatic logic [35:0] ext_mul(input logic [17:0] x, input logic [17:0] y,
                                          input bit apx);
    logic [35:0] e;
    e = 36'(x) * 36'(y);
    if (apx) e = e ^ {28'b0, x[3:0] ^ y[3:0], 4'b0};
    return e;
  endfunction

  assign mul_p = ext_mul(mul_x, mul_y, approx_en);

  karatsuba32_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .mul_x (mul_x),
    .mul_y (mul_y),
    .mul_p (mul_p)
  );

  // Reference: plain 64-bit product for the exact unit; for the approximate
  // unit, the Karatsuba identity on the unit's own products in signed 64-bit math.
  function automatic logic [63:0] ref_p(input logic [31:0] x, input logic [31:0] y,
                                        input bit apx);
    longint z2, z0, z1, r;
    if (!apx) return 64'(x) * 64'(y);
    z2 = longint'(ext_mul(18'(x[31:16]), 18'(y[31:16]), 1'b1));
    z0 = longint'(ext_mul(18'(x[15:0]), 18'(y[15:0]), 1'b1));
    z1 = longint'(ext_mul(18'(x[31:16]) + 18'(x[15:0]),
                          18'(y[31:16]) + 18'(y[15:0]), 1'b1));
    r  = (z2 <<< 32) + (z1 - z2 - z0) * 65536 + z0;
    return 64'(r);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then waits (bounded) for done; checks latency and result.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string tag);
    int n;
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 8) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd4);
    check({tag, " p"}, p, ref_p(x, y, approx_en));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          nd;
    logic [63:0] pd;

    // Reset state
    #12;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst p", p, 64'd0);
    check("rst mul_x", 64'(mul_x), 64'd0);
    check("rst mul_y", 64'(mul_y), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // All-ones operands: exercises the 17-bit half-sum carry
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
    check("max const", p, 64'hFFFF_FFFE_0000_0001);

    // Operand sequencing on the external multiplier
    a = 32'h0001_2345;
    b = 32'h0000_ABCD;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("seq HH mul_x", 64'(mul_x), 64'h1);
    check("seq HH mul_y", 64'(mul_y), 64'h0);
    check("seq HH busy", 64'(busy), 64'd1);
    tick();
    check("seq LL mul_x", 64'(mul_x), 64'h2345);
    check("seq LL mul_y", 64'(mul_y), 64'hABCD);
    tick();
    check("seq MM mul_x", 64'(mul_x), 64'h2346);
    check("seq MM mul_y", 64'(mul_y), 64'hABCD);
    tick();
    check("seq COMB mul_x", 64'(mul_x), 64'h0);
    tick();
    check("seq done", 64'(done), 64'd1);
    check("seq p", p, ref_p(32'h0001_2345, 32'h0000_ABCD, 1'b0));
    tick();
    check("seq done pulse", 64'(done), 64'd0);

    // Back-to-back: start held high through the done cycle
    a = 32'd3;
    b = 32'd5;
    start = 1'b1;
    tick();
    a = 32'd0;
    b = 32'h1234_5678;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      check($sformatf("b2b done k%0d", k), 64'(done), 64'(k == 4 || k == 9));
      check($sformatf("b2b busy k%0d", k), 64'(busy), 64'(!(k == 4 || k == 9)));
      if (k == 4) check("b2b p1", p, 64'd15);
      if (k == 9) begin
        check("b2b p2", p, 64'd0);
        start = 1'b0;
      end
    end

    // start while busy is ignored
    a = 32'h0000_1234;
    b = 32'h0000_5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 32'hFFFF_0000;
    b = 32'hEEEE_1111;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    pd = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) begin
        nd++;
        pd = p;
      end
    end
    check("ignore done count", 64'(nd), 64'd1);
    check("ignore p", pd, ref_p(32'h0000_1234, 32'h0000_5678, 1'b0));

    // Asynchronous reset during LL aborts the operation
    a = 32'hABCD_1234;
    b = 32'h1111_FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort p", p, 64'd0);
    check("abort mul_x", 64'(mul_x), 64'd0);
    check("abort mul_y", 64'(mul_y), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) nd++;
    end
    check("abort no done", 64'(nd), 64'd0);
    run_op(32'd7, 32'd9, "after abort");
    check("after abort const", p, 64'd63);

    // Approximate unit: forced z1 < z2 + z0 (z2=z0=128, z1=0, mid=-256)
    approx_en = 1'b1;
    run_op(32'h0008_0008, 32'h0000_0000, "neg mid");
    check("neg mid const", p, 64'h0000_007F_FF00_0080);

    for (int i = 0; i < 10000; i++) begin
      run_op($urandom, $urandom, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
